// File: rtl/mfp_ahb_loader_write_sequencer_pkg.sv
// Shared definitions for the loader write sequencer.
// AHB-Lite encodings, the word FIFO entry layout, bus FSM state encodings
// and small lane helpers used by the packer and the bus side.
package mfp_ahb_loader_write_sequencer_pkg;

    // AHB-Lite encodings used by this master
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] HSIZE_1       = 3'b000;
    localparam logic [2:0] HSIZE_4       = 3'b010;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    // FIFO entry layout: word address, packed data, byte-lane mask
    localparam int unsigned WORD_ADDR_W = 30;
    localparam int unsigned DATA_W      = 32;
    localparam int unsigned MASK_W      = 4;
    localparam int unsigned ENTRY_W     = WORD_ADDR_W + DATA_W + MASK_W;

    typedef struct packed {
        logic [WORD_ADDR_W-1:0] word_addr;
        logic [DATA_W-1:0]      data;
        logic [MASK_W-1:0]      mask;
    } fifo_entry_t;

    typedef enum logic [1:0] {
        BUS_IDLE = 2'd0,   // nothing on the bus
        BUS_ADDR = 2'd1,   // address phase only
        BUS_DATA = 2'd2,   // data phase, possibly with a pipelined address
        BUS_ERR  = 2'd3    // second cycle of an ERROR response
    } bus_state_e;

    // Lowest set lane of a byte mask (lane 3 if only bit 3 or none)
    function automatic logic [1:0] lowest_lane(input logic [3:0] m);
        if (m[0])      return 2'd0;
        else if (m[1]) return 2'd1;
        else if (m[2]) return 2'd2;
        else           return 2'd3;
    endfunction

    // 32-bit mask selecting byte lane 'lane' (little-endian)
    function automatic logic [31:0] lane_mask(input logic [1:0] lane);
        return 32'h0000_00FF << {lane, 3'b000};
    endfunction

endpackage

// File: rtl/mfp_ahb_loader_word_fifo.sv
// Synchronous FIFO of committed words between the packer and the bus FSM.
// Ports: clock, reset (sync, active-high), push/push_data, pop,
//        full, empty, head (entry at the read pointer, valid when !empty).
module mfp_ahb_loader_word_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 66
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [CNT_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    // Extra pointer bit distinguishes full from empty
    always_comb begin
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + CNT_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + CNT_W'(1);
        head     = mem_q[rd_ptr_q[PTR_W-1:0]];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: entries are only read while the FIFO is non-empty
    always_ff @(posedge clock) begin
        if (do_push) mem_q[wr_ptr_q[PTR_W-1:0]] <= push_data;
    end

endmodule

// File: rtl/mfp_ahb_loader_write_sequencer.sv
// Loader write sequencer: packs parser bytes into words and writes them
// over an AHB-Lite master port.
// Ports: clock/reset (sync, active-high); parser side write_address,
//        write_byte, write_enable, write_ready, flush; status busy, error;
//        AHB-Lite master HADDR..HWRITE out, HREADY/HRESP in.
module mfp_ahb_loader_write_sequencer
    import mfp_ahb_loader_write_sequencer_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned CLEAR_TOP_BITS = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] write_address,
    input  logic [7:0]  write_byte,
    input  logic        write_enable,
    output logic        write_ready,
    input  logic        flush,
    output logic        busy,
    output logic        error,
    output logic [31:0] HADDR,
    output logic [2:0]  HBURST,
    output logic        HMASTLOCK,
    output logic [3:0]  HPROT,
    output logic [2:0]  HSIZE,
    output logic [1:0]  HTRANS,
    output logic [31:0] HWDATA,
    output logic        HWRITE,
    input  logic        HREADY,
    input  logic        HRESP
);

    localparam logic [31:0] ADDR_KEEP = 32'hFFFF_FFFF >> CLEAR_TOP_BITS;

    // Packer state
    logic [29:0] pk_addr_q, pk_addr_d;
    logic [31:0] pk_data_q, pk_data_d;
    logic [3:0]  pk_mask_q, pk_mask_d;
    logic        flush_pend_q, flush_pend_d;

    // Bus side state
    bus_state_e  state_q, state_d;
    logic [3:0]  done_q, done_d;
    logic [31:0] hwdata_q, hwdata_d;
    logic        error_q, error_d;

    // FIFO interface
    fifo_entry_t push_entry;
    fifo_entry_t head_entry;
    logic        fifo_push;
    logic        fifo_pop;
    logic        fifo_full;
    logic        fifo_empty;

    // Packer decode
    logic [29:0] in_word;
    logic [1:0]  in_lane;
    logic [3:0]  lane_bit;
    logic        conflict;
    logic        flush_req;
    logic [31:0] merged_data;

    // Bus decode
    logic [3:0]  remaining;
    logic        full_word;
    logic [1:0]  cur_lane;
    logic        last_xfer;
    logic        addr_phase;
    logic        addr_accept;

    mfp_ahb_loader_word_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (push_entry),
        .pop       (fifo_pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (head_entry)
    );

    // Packer: merge accepted bytes, decide when the current word commits
    always_comb begin
        in_word     = write_address[31:2];
        in_lane     = write_address[1:0];
        lane_bit    = 4'b0001 << in_lane;
        conflict    = write_enable && (pk_mask_q != 4'd0) &&
                      ((in_word != pk_addr_q) || ((pk_mask_q & lane_bit) != 4'd0));
        flush_req   = flush || flush_pend_q;
        merged_data = (pk_data_q & ~lane_mask(in_lane)) |
                      (32'(write_byte) << {in_lane, 3'b000});

        pk_addr_d    = pk_addr_q;
        pk_data_d    = pk_data_q;
        pk_mask_d    = pk_mask_q;
        flush_pend_d = 1'b0;
        fifo_push    = 1'b0;
        push_entry   = '{word_addr: pk_addr_q, data: pk_data_q, mask: pk_mask_q};
        write_ready  = 1'b1;

        if (conflict) begin
            // Old word leaves first; the parser holds the byte for one more cycle
            write_ready  = 1'b0;
            flush_pend_d = flush_req;
            if (!fifo_full) begin
                fifo_push = 1'b1;
                pk_mask_d = 4'd0;
            end
        end else if (write_enable) begin
            if ((in_lane == 2'd3) || flush_req) begin
                // Byte is packed and the word commits in the same cycle
                if (fifo_full) begin
                    write_ready  = 1'b0;
                    flush_pend_d = flush_req;
                end else begin
                    fifo_push  = 1'b1;
                    push_entry = '{word_addr: in_word, data: merged_data,
                                   mask: pk_mask_q | lane_bit};
                    pk_mask_d  = 4'd0;
                end
            end else begin
                pk_addr_d = in_word;
                pk_data_d = merged_data;
                pk_mask_d = pk_mask_q | lane_bit;
            end
        end else if (flush_req && (pk_mask_q != 4'd0)) begin
            write_ready = !fifo_full;
            if (fifo_full) begin
                flush_pend_d = 1'b1;
            end else begin
                fifo_push = 1'b1;
                pk_mask_d = 4'd0;
            end
        end
    end

    // Bus FSM state register
    always_ff @(posedge clock) begin
        if (reset) state_q <= BUS_IDLE;
        else       state_q <= state_d;
    end

    // Bus FSM next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            BUS_IDLE: if (fifo_push || !fifo_empty) state_d = BUS_ADDR;
            BUS_ADDR: if (HREADY) state_d = BUS_DATA;
            BUS_DATA: begin
                if (!HREADY) begin
                    if (HRESP) state_d = BUS_ERR;
                end else if (addr_phase) begin
                    state_d = BUS_DATA;
                end else if (fifo_push) begin
                    state_d = BUS_ADDR;
                end else begin
                    state_d = BUS_IDLE;
                end
            end
            BUS_ERR: begin
                if (HREADY) state_d = (fifo_push || !fifo_empty) ? BUS_ADDR : BUS_IDLE;
            end
            default: state_d = BUS_IDLE;
        endcase
    end

    // Bus FSM outputs: address phase from FIFO head, data phase from hwdata_q
    always_comb begin
        remaining   = head_entry.mask & ~done_q;
        full_word   = (head_entry.mask == 4'hF);
        cur_lane    = full_word ? 2'd0 : lowest_lane(remaining);
        last_xfer   = full_word || ((remaining & (remaining - 4'd1)) == 4'd0);
        // ERR state drives IDLE, which cancels any pipelined address
        addr_phase  = (state_q == BUS_ADDR) || ((state_q == BUS_DATA) && !fifo_empty);
        addr_accept = addr_phase && HREADY;

        HTRANS    = addr_phase ? HTRANS_NONSEQ : HTRANS_IDLE;
        HWRITE    = addr_phase;
        HSIZE     = (addr_phase && !full_word) ? HSIZE_1 : HSIZE_4;
        HADDR     = addr_phase ? ({head_entry.word_addr, cur_lane} & ADDR_KEEP) : 32'd0;
        HBURST    = HBURST_SINGLE;
        HMASTLOCK = 1'b0;
        HPROT     = 4'd0;
        HWDATA    = hwdata_q;
        error     = error_q;
        busy      = (pk_mask_q != 4'd0) || !fifo_empty || (state_q != BUS_IDLE);

        hwdata_d = hwdata_q;
        done_d   = done_q;
        fifo_pop = 1'b0;
        if (addr_accept) begin
            hwdata_d = full_word ? head_entry.data
                                 : (head_entry.data & lane_mask(cur_lane));
            done_d   = last_xfer ? 4'd0 : (done_q | (4'b0001 << cur_lane));
            fifo_pop = last_xfer;
        end
        error_d = error_q || ((state_q == BUS_DATA) && !HREADY && HRESP);
    end

    // Datapath registers
    always_ff @(posedge clock) begin
        if (reset) begin
            pk_addr_q    <= '0;
            pk_data_q    <= '0;
            pk_mask_q    <= '0;
            flush_pend_q <= 1'b0;
            done_q       <= '0;
            hwdata_q     <= '0;
            error_q      <= 1'b0;
        end else begin
            pk_addr_q    <= pk_addr_d;
            pk_data_q    <= pk_data_d;
            pk_mask_q    <= pk_mask_d;
            flush_pend_q <= flush_pend_d;
            done_q       <= done_d;
            hwdata_q     <= hwdata_d;
            error_q      <= error_d;
        end
    end

endmodule

// File: tb/tb_mfp_ahb_loader_write_sequencer.sv
// Directed bench for the loader write sequencer: byte packing, partial
// writes, address jumps, wait states, back-pressure, ERROR and reset.
module tb_mfp_ahb_loader_write_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] write_address;
    logic [7:0]  write_byte;
    logic        write_enable;
    logic        write_ready;
    logic        flush;
    logic        busy;
    logic        error;
    logic [31:0] HADDR;
    logic [2:0]  HBURST;
    logic        HMASTLOCK;
    logic [3:0]  HPROT;
    logic [2:0]  HSIZE;
    logic [1:0]  HTRANS;
    logic [31:0] HWDATA;
    logic        HWRITE;
    logic        HREADY;
    logic        HRESP;

    always #5 clock = ~clock;

    mfp_ahb_loader_write_sequencer dut (
        .clock         (clock),
        .reset         (reset),
        .write_address (write_address),
        .write_byte    (write_byte),
        .write_enable  (write_enable),
        .write_ready   (write_ready),
        .flush         (flush),
        .busy          (busy),
        .error         (error),
        .HADDR         (HADDR),
        .HBURST        (HBURST),
        .HMASTLOCK     (HMASTLOCK),
        .HPROT         (HPROT),
        .HSIZE         (HSIZE),
        .HTRANS        (HTRANS),
        .HWDATA        (HWDATA),
        .HWRITE        (HWRITE),
        .HREADY        (HREADY),
        .HRESP         (HRESP)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] log_addr [$];
    logic [2:0]  log_size [$];
    logic [31:0] log_data [$];
    bit          dpend = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // One clock: observe bus at the falling edge, return just after the rising edge
    task automatic cycle(output logic rdy);
        @(negedge clock);
        rdy = write_ready;
        if (dpend && HREADY) begin
            log_data.push_back(HWDATA);
            dpend = 1'b0;
        end
        if (HTRANS == 2'b10 && HREADY) begin
            log_addr.push_back(HADDR);
            log_size.push_back(HSIZE);
            dpend = 1'b1;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic tick();
        logic r;
        cycle(r);
    endtask

    task automatic clear_log();
        log_addr.delete();
        log_size.delete();
        log_data.delete();
    endtask

    task automatic send_byte(input logic [31:0] a, input logic [7:0] b, output int waits);
        logic r;
        r = 1'b0;
        waits = 0;
        write_address = a;
        write_byte    = b;
        write_enable  = 1'b1;
        for (int i = 0; i < 64; i++) begin
            cycle(r);
            if (r) break;
            waits++;
        end
        write_enable = 1'b0;
        if (!r) check_eq("send_accept", 64'(r), 64'(1));
    endtask

    task automatic send_word(input logic [31:0] base, input logic [31:0] w, output int waits);
        int wt;
        waits = 0;
        for (int k = 0; k < 4; k++) begin
            send_byte(base + 32'(k), w[8*k +: 8], wt);
            waits += wt;
        end
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 100 && busy; i++) tick();
        check_eq(tag, 64'(busy), 64'(0));
    endtask

    task automatic check_xfer(input string tag, input int i, input logic [31:0] a,
                              input logic [2:0] s, input logic [31:0] d);
        logic [31:0] ga, gd;
        logic [2:0]  gs;
        ga = (i < log_addr.size()) ? log_addr[i] : 32'hxxxx_xxxx;
        gs = (i < log_size.size()) ? log_size[i] : 3'bxxx;
        gd = (i < log_data.size()) ? log_data[i] : 32'hxxxx_xxxx;
        check_eq({tag, "_haddr"}, 64'(ga), 64'(a));
        check_eq({tag, "_hsize"}, 64'(gs), 64'(s));
        check_eq({tag, "_hwdata"}, 64'(gd), 64'(d));
    endtask

    logic [31:0] words [6];
    int          wt;
    logic        r;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; write_enable = 1'b0; write_address = '0; write_byte = '0;
        flush = 1'b0; HREADY = 1'b1; HRESP = 1'b0;
        tick(); tick();
        check_eq("rst_htrans", 64'(HTRANS), 64'(0));
        check_eq("rst_hwrite", 64'(HWRITE), 64'(0));
        check_eq("rst_haddr", 64'(HADDR), 64'(0));
        check_eq("rst_hsize", 64'(HSIZE), 64'(2));
        check_eq("rst_hwdata", 64'(HWDATA), 64'(0));
        check_eq("rst_ready", 64'(write_ready), 64'(1));
        check_eq("rst_busy", 64'(busy), 64'(0));
        check_eq("rst_error", 64'(error), 64'(0));
        check_eq("rst_hburst", 64'(HBURST), 64'(0));
        reset = 1'b0;
        tick();

        // Full aligned word with KSEG remap
        clear_log();
        send_word(32'hBFC0_0000, 32'h4433_2211, wt);
        check_eq("t1_waits", 64'(wt), 64'(0));
        check_eq("t1_htrans", 64'(HTRANS), 64'(2));
        check_eq("t1_haddr", 64'(HADDR), 64'h1FC0_0000);
        check_eq("t1_hsize", 64'(HSIZE), 64'(2));
        check_eq("t1_hwrite", 64'(HWRITE), 64'(1));
        tick();
        check_eq("t1_hwdata", 64'(HWDATA), 64'h4433_2211);
        check_eq("t1_idle", 64'(HTRANS), 64'(0));
        check_eq("t1_busy_mid", 64'(busy), 64'(1));
        tick();
        check_eq("t1_busy_done", 64'(busy), 64'(0));
        check_eq("t1_count", 64'(log_addr.size()), 64'(1));
        check_eq("t1_error", 64'(error), 64'(0));

        // Partial word then flush
        clear_log();
        send_byte(32'h0000_1001, 8'hAA, wt);
        send_byte(32'h0000_1002, 8'hBB, wt);
        check_eq("t2_busy_packed", 64'(busy), 64'(1));
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drain("t2_drain");
        check_eq("t2_count", 64'(log_addr.size()), 64'(2));
        check_xfer("t2_x0", 0, 32'h0000_1001, 3'd0, 32'h0000_AA00);
        check_xfer("t2_x1", 1, 32'h0000_1002, 3'd0, 32'h00BB_0000);

        // Word-address jump
        clear_log();
        send_byte(32'h0000_2000, 8'h5A, wt);
        send_byte(32'h0000_2008, 8'h6B, wt);
        check_eq("t3_stall", 64'(wt), 64'(1));
        repeat (4) tick();
        check_eq("t3_count", 64'(log_addr.size()), 64'(1));
        check_xfer("t3_x0", 0, 32'h0000_2000, 3'd0, 32'h0000_005A);
        check_eq("t3_held", 64'(busy), 64'(1));
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drain("t3_drain");
        check_xfer("t3_x1", 1, 32'h0000_2008, 3'd0, 32'h0000_006B);

        // Wait states in a data phase with a pipelined address
        clear_log();
        HREADY = 1'b0;
        words[0] = 32'hA3A2_A1A0; words[1] = 32'hB3B2_B1B0; words[2] = 32'hC3C2_C1C0;
        for (int k = 0; k < 3; k++) send_word(32'h0000_0100 + 32'(4*k), words[k], wt);
        HREADY = 1'b1;
        tick();
        HREADY = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check_eq("t4_haddr_hold", 64'(HADDR), 64'h0000_0104);
            check_eq("t4_hwdata_hold", 64'(HWDATA), 64'(words[0]));
            check_eq("t4_htrans_hold", 64'(HTRANS), 64'(2));
            tick();
        end
        HREADY = 1'b1;
        drain("t4_drain");
        check_eq("t4_count", 64'(log_addr.size()), 64'(3));
        for (int k = 0; k < 3; k++)
            check_xfer("t4_x", k, 32'h0000_0100 + 32'(4*k), 3'd2, words[k]);

        // Back-pressure with the bus stalled
        clear_log();
        HREADY = 1'b0;
        for (int k = 0; k < 6; k++) words[k] = {4{8'(8'h10 * (k + 1))}} + 32'h0302_0100;
        for (int k = 0; k < 4; k++) begin
            send_word(32'h0000_0400 + 32'(4*k), words[k], wt);
            check_eq("t5_no_stall", 64'(wt), 64'(0));
        end
        for (int k = 0; k < 3; k++) send_byte(32'h0000_0410 + 32'(k), words[4][8*k +: 8], wt);
        write_address = 32'h0000_0413; write_byte = words[4][31:24]; write_enable = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cycle(r);
            check_eq("t5_ready_low", 64'(r), 64'(0));
        end
        HREADY = 1'b1;
        send_byte(32'h0000_0413, words[4][31:24], wt);
        check_eq("t5_release", 64'(wt), 64'(1));
        send_word(32'h0000_0414, words[5], wt);
        drain("t5_drain");
        check_eq("t5_count", 64'(log_addr.size()), 64'(6));
        for (int k = 0; k < 6; k++)
            check_xfer("t5_x", k, 32'h0000_0400 + 32'(4*k), 3'd2, words[k]);

        // ERROR response on the first of two words
        clear_log();
        HREADY = 1'b0;
        send_word(32'h0000_0300, 32'h0302_0100, wt);
        send_word(32'h0000_0304, 32'h0706_0504, wt);
        HREADY = 1'b1;
        tick();
        check_eq("t6_pipelined", 64'(HTRANS), 64'(2));
        check_eq("t6_pipe_addr", 64'(HADDR), 64'h0000_0304);
        HREADY = 1'b0; HRESP = 1'b1;
        tick();
        check_eq("t6_error", 64'(error), 64'(1));
        check_eq("t6_cancel", 64'(HTRANS), 64'(0));
        HREADY = 1'b1;
        tick();
        HRESP = 1'b0;
        check_eq("t6_retry", 64'(HTRANS), 64'(2));
        check_eq("t6_retry_addr", 64'(HADDR), 64'h0000_0304);
        drain("t6_drain");
        check_eq("t6_count", 64'(log_addr.size()), 64'(2));
        check_xfer("t6_x0", 0, 32'h0000_0300, 3'd2, 32'h0302_0100);
        check_xfer("t6_x1", 1, 32'h0000_0304, 3'd2, 32'h0706_0504);
        check_eq("t6_sticky", 64'(error), 64'(1));

        // Reset mid-stream
        HREADY = 1'b0;
        send_word(32'h0000_0500, 32'hDDCC_BBAA, wt);
        send_byte(32'h0000_0504, 8'h77, wt);
        reset = 1'b1;
        tick();
        check_eq("t7_htrans", 64'(HTRANS), 64'(0));
        check_eq("t7_haddr", 64'(HADDR), 64'(0));
        check_eq("t7_hwdata", 64'(HWDATA), 64'(0));
        check_eq("t7_hsize", 64'(HSIZE), 64'(2));
        check_eq("t7_hwrite", 64'(HWRITE), 64'(0));
        check_eq("t7_busy", 64'(busy), 64'(0));
        check_eq("t7_error", 64'(error), 64'(0));
        check_eq("t7_ready", 64'(write_ready), 64'(1));
        reset = 1'b0;
        HREADY = 1'b1;
        dpend = 1'b0;
        tick();
        check_eq("t7_stay_idle", 64'(busy), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
